// File: rtl/mux2_1_reg.sv
// 2-to-1 mux with a combinational output, a registered copy, and output-change tracking
// (single-cycle change pulse plus a saturating change counter).
module mux2_1_reg #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             s,
  input  logic             en,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             sel_q,
  output logic             y_chg,
  output logic [CNT_W-1:0] chg_cnt
);

  logic [WIDTH-1:0] r_y_q;
  logic             r_sel_q;
  logic             r_y_chg;
  logic [CNT_W-1:0] r_chg_cnt;
  logic             w_diff;
  logic             w_cnt_sat;

  assign y         = s ? i1 : i0;
  assign w_diff    = (y != r_y_q);
  assign w_cnt_sat = &r_chg_cnt;

  // Change is judged against the value currently held in y_q, so only sampled values count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y_q   <= '0;
      r_sel_q <= 1'b0;
      r_y_chg <= 1'b0;
    end else if (en) begin
      r_y_q   <= y;
      r_sel_q <= s;
      r_y_chg <= w_diff;
    end else begin
      r_y_chg <= 1'b0;
    end
  end

  // Clear wins over increment; the counter sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chg_cnt <= '0;
    end else if (clr_cnt) begin
      r_chg_cnt <= '0;
    end else if (en && w_diff && !w_cnt_sat) begin
      r_chg_cnt <= r_chg_cnt + 1'b1;
    end
  end

  assign y_q     = r_y_q;
  assign sel_q   = r_sel_q;
  assign y_chg   = r_y_chg;
  assign chg_cnt = r_chg_cnt;

endmodule

// File: tb/tb_mux2_1_reg.sv
// Bench for mux2_1_reg: three instances (1-bit/16-bit counter, 1-bit/3-bit counter,
// 8-bit/4-bit counter) driven in lockstep and compared against a behavioural model.
module tb_mux2_1_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i0, i1;
  logic       s, en, clr_cnt;

  always #5 clk = ~clk;

  logic        a_y, a_yq, a_sel, a_chg;
  logic [15:0] a_cnt;
  logic        b_y, b_yq, b_sel, b_chg;
  logic [2:0]  b_cnt;
  logic [7:0]  c_y, c_yq;
  logic        c_sel, c_chg;
  logic [3:0]  c_cnt;

  mux2_1_reg #(.WIDTH(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .i0(i0[0]), .i1(i1[0]), .s(s), .en(en), .clr_cnt(clr_cnt),
    .y(a_y), .y_q(a_yq), .sel_q(a_sel), .y_chg(a_chg), .chg_cnt(a_cnt));

  mux2_1_reg #(.WIDTH(1), .CNT_W(3)) u_b (
    .clk(clk), .rst(rst), .i0(i0[0]), .i1(i1[0]), .s(s), .en(en), .clr_cnt(clr_cnt),
    .y(b_y), .y_q(b_yq), .sel_q(b_sel), .y_chg(b_chg), .chg_cnt(b_cnt));

  mux2_1_reg #(.WIDTH(8), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .i0(i0), .i1(i1), .s(s), .en(en), .clr_cnt(clr_cnt),
    .y(c_y), .y_q(c_yq), .sel_q(c_sel), .y_chg(c_chg), .chg_cnt(c_cnt));

  // Observed outputs gathered per instance
  logic [7:0]  d_y [3];
  logic [7:0]  d_yq [3];
  logic        d_sel [3];
  logic        d_chg [3];
  logic [15:0] d_cnt [3];

  assign d_y[0]   = {7'b0, a_y};
  assign d_y[1]   = {7'b0, b_y};
  assign d_y[2]   = c_y;
  assign d_yq[0]  = {7'b0, a_yq};
  assign d_yq[1]  = {7'b0, b_yq};
  assign d_yq[2]  = c_yq;
  assign d_sel[0] = a_sel;
  assign d_sel[1] = b_sel;
  assign d_sel[2] = c_sel;
  assign d_chg[0] = a_chg;
  assign d_chg[1] = b_chg;
  assign d_chg[2] = c_chg;
  assign d_cnt[0] = a_cnt;
  assign d_cnt[1] = {13'b0, b_cnt};
  assign d_cnt[2] = {12'b0, c_cnt};

  // Behavioural model state per instance
  int         mask [3] = '{1, 1, 255};
  int         cmax [3] = '{65535, 7, 15};
  int         m_yq [3];
  int         m_sel [3];
  int         m_chg [3];
  int         m_cnt [3];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input int k, input int act, input int exp);
    n_checks++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, k, act, exp);
    end
  endtask

  function automatic int model_y(input int k);
    int choice [2];
    choice[0] = int'(i0);
    choice[1] = int'(i1);
    return choice[s] & mask[k];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_yq[k] = 0; m_sel[k] = 0; m_chg[k] = 0; m_cnt[k] = 0;
    end
  endtask

  // One rising edge as seen from the outside: sample y, remember it, count changes.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int yv;
      bit changed;
      yv      = model_y(k);
      changed = en && (yv != m_yq[k]);
      if (en) begin
        m_yq[k]  = yv;
        m_sel[k] = s;
      end
      m_chg[k] = changed;
      if (clr_cnt)      m_cnt[k] = 0;
      else if (changed) m_cnt[k] = (m_cnt[k] < cmax[k]) ? m_cnt[k] + 1 : m_cnt[k];
    end
  endtask

  task automatic check_y();
    for (int k = 0; k < 3; k++) chk("y", k, int'(d_y[k]), model_y(k));
  endtask

  task automatic check_regs();
    for (int k = 0; k < 3; k++) begin
      chk("y_q", k, int'(d_yq[k]), m_yq[k]);
      chk("sel_q", k, int'(d_sel[k]), m_sel[k]);
      chk("y_chg", k, int'(d_chg[k]), m_chg[k]);
      chk("chg_cnt", k, int'(d_cnt[k]), m_cnt[k]);
    end
  endtask

  // Apply inputs between edges, check y, take one edge, check the registers.
  task automatic step(input logic [7:0] v0, input logic [7:0] v1, input logic vs,
                      input logic ven, input logic vclr);
    i0 = v0; i1 = v1; s = vs; en = ven; clr_cnt = vclr;
    #1;
    check_y();
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
    $display("step t=%0t i0=%h i1=%h s=%b en=%b clr=%b -> y_c=%h y_q_c=%h chg=%b%b%b cnt_b=%0d",
             $time, v0, v1, vs, ven, vclr, c_y, c_yq, a_chg, b_chg, c_chg, b_cnt);
  endtask

  int toggle_y [10] = '{0, 0, 0, 1, 1, 0, 1, 1, 0, 0};

  initial begin
    rst = 1'b1; i0 = '0; i1 = '0; s = 1'b0; en = 1'b1; clr_cnt = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_regs();

    rst = 1'b0;

    // Truth table for every (s,i1,i0)
    for (int v = 0; v < 8; v++) begin
      step({8{v[0]}}, {8{v[1]}}, v[2], 1'b1, 1'b0);
      chk("truth_y", 0, int'(a_y), v[2] ? v[1] : v[0]);
    end

    // Toggle pattern: i0 /40ns, i1 /20ns, s /10ns
    for (int t = 0; t < 10; t++) begin
      i0 = {8{1'((t / 4) % 2)}}; i1 = {8{1'((t / 2) % 2)}}; s = 1'(t % 2);
      #1;
      chk("toggle_y", 0, int'(a_y), toggle_y[t]);
      step(i0, i1, s, 1'b1, 1'b0);
    end

    // Asynchronous reset between edges while y=1
    step(8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
    step(8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_yq", 0, int'(a_yq), 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_regs();
    chk("rst_y_follows", 0, int'(a_y), 1);
    rst = 1'b0;
    step(8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("post_rst_chg", 0, int'(a_chg), 1);
    chk("post_rst_cnt", 0, int'(a_cnt), 1);

    // Enable low while y toggles: everything holds, no pulse
    for (int n = 0; n < 5; n++) step({7'b0, 1'(n % 2 == 0 ? 0 : 1)}, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("en_hold_cnt", 0, int'(a_cnt), 1);
    step(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("en_resume_yq", 0, int'(a_yq), 0);

    // Saturation of the 3-bit counter, then clear while changing
    for (int n = 0; n < 10; n++) step({7'b0, 1'(n % 2 == 0 ? 1 : 0)}, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("sat_cnt", 1, int'(b_cnt), 7);
    step(8'h01, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("clr_cnt", 1, int'(b_cnt), 0);
    chk("clr_chg", 1, int'(b_chg), 1);

    // 8-bit data: alternation, then equal inputs with s toggling
    for (int n = 0; n < 4; n++) begin
      step(8'hA5, 8'h3C, 1'(n % 2), 1'b1, 1'b0);
      chk("w8_yq", 2, int'(c_yq), (n % 2) ? 'h3C : 'hA5);
    end
    step(8'h77, 8'h77, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 4; n++) begin
      step(8'h77, 8'h77, 1'(n % 2 == 0), 1'b1, 1'b0);
      chk("w8_nochg", 2, int'(c_chg), 0);
    end

    // Randomized traffic with occasional clears, enable drops and async resets
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_regs();
        rst = 1'b0;
      end
      step(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mux2_1_reg.md
Name: mux2_1_reg

Overview:
- Parameterised 2-to-1 multiplexer with a combinational output, a registered copy of that output, and output-change tracking.
- Used wherever a select-steered data path must be available both immediately (same cycle) and retimed to the clock domain.
- The change pulse and saturating change counter support run-time monitoring of output activity.

Parameters:
- WIDTH, 1, bit width of i0, i1, y, y_q.
- CNT_W, 16, width of the output-change counter.

Ports:
- clk  input  1  rising-edge clock for all registers.
- rst  input  1  asynchronous, active-high reset.
- i0  input  WIDTH  data input selected when s=0.
- i1  input  WIDTH  data input selected when s=1.
- s  input  1  select.
- en  input  1  register enable for y_q, sel_q, y_chg, chg_cnt.
- clr_cnt  input  1  synchronous clear of chg_cnt.
- y  output  WIDTH  combinational mux output.
- y_q  output  WIDTH  registered mux output.
- sel_q  output  1  registered copy of s, captured with y_q.
- y_chg  output  1  one-cycle pulse: y_q changed on this edge.
- chg_cnt  output  CNT_W  saturating count of y_q changes.

Behaviour:
- Combinational path:
  - y = i1 when s=1, else i0.
  - Pure combinational, zero latency, independent of clk, rst and en.
  - Every bit is selected by the same s.
- Reset (rst=1, asynchronous, takes effect immediately with no clock edge): y_q=0, sel_q=0, y_chg=0, chg_cnt=0.
  - y keeps following its inputs during reset.
- Rising clk edge, rst=0, en=1:
  - y_q <= y and sel_q <= s, giving one-cycle latency from inputs to y_q.
  - y_chg <= 1 if y differs from the current y_q, else 0.
  - If y_chg is being set and chg_cnt < all-ones, chg_cnt increments by 1; at all-ones it holds (saturates, no wrap).
- Rising clk edge, rst=0, en=0:
  - y_q, sel_q and chg_cnt hold.
  - y_chg <= 0, so a pulse never lasts more than one cycle.
- clr_cnt=1 on an edge (rst=0):
  - chg_cnt <= 0 regardless of en.
  - clr_cnt has priority over increment; a change detected in that same cycle is not counted.
  - y_chg still reflects the change.
- Reset deasserting mid-operation: the first enabled edge compares against y_q=0.
  - If y is non-zero at that edge, y_chg pulses and chg_cnt becomes 1.
- Simultaneous change of s and data that leaves y unchanged: no y_chg pulse.
- Glitches on y between clock edges are not detected; only sampled values count.

Test Plan:
- Truth table, WIDTH=1, combinational, all 8 combinations of (s,i1,i0) -> y=i0 when s=0, y=i1 when s=1. Check (0,1,0)->0, (1,1,0)->1, (1,0,1)->0, (0,0,1)->1.
- Toggle pattern: i0 toggles every 40 ns, i1 every 20 ns, s every 10 ns, all starting at 0, over 100 ns.
  - y reads 0,0,0,1,1,0,1,1,0,0 in 10 ns steps from t=0.
  - y_q tracks y one clk edge later with a 10 ns clock and en=1.
- Reset: drive i0=1, s=0 and clock until y_q=1; assert rst between edges.
  - y_q, sel_q, y_chg and chg_cnt read 0 immediately.
  - y stays 1.
  - After release, the first edge gives y_q=1, y_chg=1, chg_cnt=1.
- Enable: en=0 while y toggles for 5 edges -> y_q, chg_cnt hold and y_chg=0. Then set en=1 -> update on the next edge.
- Saturation: CNT_W=3, toggle y every cycle for 10 cycles -> chg_cnt reaches 7 and stays at 7. Then clr_cnt=1 for one edge while y changes -> chg_cnt=0, y_chg=1.
- Width: WIDTH=8, i0=8'hA5, i1=8'h3C, toggle s -> y alternates A5/3C. No y_chg when i0=i1=8'h77 and s toggles.
